gnss_corr_bank: RTL and testbench

Parametrised multi-tap code correlator and integrate-and-dump engine for the tracking channels. It accepts the carrier-wiped {Q,I} sample stream and one replica code chip per tap (VE/E/P/L/VL/Pilot or any count). It skips a programmable number of leading samples, then accumulates signed I/Q per tap over a programmable integration length. Each epoch's results are presented on an AXI-Stream master with back-pressure, overrun detection, single-shot or continuous mode, and saturating accumulators.

---
 rtl/gnss_corr_bank_pkg.sv | 38 +++
 rtl/gnss_corr_tap_acc.sv | 80 ++++++++
 rtl/gnss_corr_bank.sv | 192 +++++++++++++++++++
 tb/tb_gnss_corr_bank.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gnss_corr_bank_pkg.sv
// Shared definitions for the GNSS correlator bank.
//   state_t   : engine states (IDLE, SKIP, INTEG, DRAIN)
//   CHIP_POS  : replica chip value that means +1 (the other value means -1)
//   sat_add   : signed add clipped to a w-bit two's-complement range
package gnss_corr_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SKIP  = 2'd1,
    ST_INTEG = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic CHIP_POS = 1'b1;

  // Working width of the saturating adder; callers use w < SAT_W.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_add(
    input logic signed [SAT_W-1:0] a,
    input logic signed [SAT_W-1:0] b,
    input int unsigned             w
  );
    logic signed [SAT_W-1:0] sum;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sum = a + b;
    hi  = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (w - 1));
    if (sum > hi) begin
      return hi;
    end else if (sum < lo) begin
      return lo;
    end
    return sum;
  endfunction

endpackage

// File: rtl/gnss_corr_tap_acc.sv
// One correlator tap: signed I/Q term register plus saturating accumulators.
//   clk, rst        : clock, asynchronous active-high reset
//   clr             : synchronous clear of terms and accumulators
//   smp_en          : load a new term from smp_re/smp_im/code
//   acc_en          : add the registered term into the accumulators
//   restart         : previous update closed an epoch; next add starts from 0
//   acc_re, acc_im  : current accumulator values
module gnss_corr_tap_acc
  import gnss_corr_bank_pkg::*;
#(
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       smp_en,
  input  logic                       acc_en,
  input  logic                       restart,
  input  logic                       code,
  input  logic signed [SAMPLE_W-1:0] smp_re,
  input  logic signed [SAMPLE_W-1:0] smp_im,
  output logic signed [ACC_W-1:0]    acc_re,
  output logic signed [ACC_W-1:0]    acc_im
);

  // One extra bit so that negating the most negative sample is exact.
  logic signed [SAMPLE_W:0] re_x, im_x;
  logic signed [SAMPLE_W:0] term_re_q, term_re_d, term_im_q, term_im_d;
  logic signed [ACC_W-1:0]  acc_re_q, acc_re_d, acc_im_q, acc_im_d;
  logic signed [ACC_W-1:0]  base_re, base_im;

  assign re_x = {smp_re[SAMPLE_W-1], smp_re};
  assign im_x = {smp_im[SAMPLE_W-1], smp_im};

  // After an epoch closes the accumulator still shows the dumped value;
  // the first term of the next epoch is added to zero instead.
  assign base_re = restart ? '0 : acc_re_q;
  assign base_im = restart ? '0 : acc_im_q;

  always_comb begin
    term_re_d = term_re_q;
    term_im_d = term_im_q;
    acc_re_d  = acc_re_q;
    acc_im_d  = acc_im_q;
    if (clr) begin
      term_re_d = '0;
      term_im_d = '0;
      acc_re_d  = '0;
      acc_im_d  = '0;
    end else begin
      if (smp_en) begin
        term_re_d = (code == CHIP_POS) ? re_x : -re_x;
        term_im_d = (code == CHIP_POS) ? im_x : -im_x;
      end
      if (acc_en) begin
        acc_re_d = ACC_W'(sat_add(SAT_W'(base_re), SAT_W'(term_re_q), ACC_W));
        acc_im_d = ACC_W'(sat_add(SAT_W'(base_im), SAT_W'(term_im_q), ACC_W));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      term_re_q <= '0;
      term_im_q <= '0;
      acc_re_q  <= '0;
      acc_im_q  <= '0;
    end else begin
      term_re_q <= term_re_d;
      term_im_q <= term_im_d;
      acc_re_q  <= acc_re_d;
      acc_im_q  <= acc_im_d;
    end
  end

  assign acc_re = acc_re_q;
  assign acc_im = acc_im_q;

endmodule

// File: rtl/gnss_corr_bank.sv
// Multi-tap code correlator with integrate-and-dump and AXI-Stream output.
//   axis_aclk / axis_aresetn : clock / asynchronous active-high reset
//   i_start, i_stop          : run control pulses (stop has priority)
//   i_cfg_*                  : epoch length, leading skip, continuous mode
//   s_axis_*, i_code         : {Q,I} samples and one replica chip per tap
//   m_axis_*                 : per-epoch results, tap k at [2*ACC_W*k +: 2*ACC_W]
//   o_busy, o_overrun, o_epoch_count : status
module gnss_corr_bank
  import gnss_corr_bank_pkg::*;
#(
  parameter int NUM_TAPS = 6,
  parameter int SAMPLE_W = 8,
  parameter int ACC_W    = 32,
  parameter int LEN_W    = 32
) (
  input  logic                          axis_aclk,
  input  logic                          axis_aresetn,
  input  logic                          i_start,
  input  logic                          i_stop,
  input  logic [LEN_W-1:0]              i_cfg_len,
  input  logic [LEN_W-1:0]              i_cfg_skip,
  input  logic                          i_cfg_continuous,
  input  logic [2*SAMPLE_W-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  input  logic [NUM_TAPS-1:0]           i_code,
  output logic [2*ACC_W*NUM_TAPS-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          o_busy,
  output logic                          o_overrun,
  output logic [15:0]                   o_epoch_count
);

  localparam int OUT_W = 2 * ACC_W * NUM_TAPS;
  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d, skip_q, skip_d, last_idx_q, last_idx_d;
  logic               cont_q, cont_d;
  logic               term_vld_q, term_vld_d, term_last_q, term_last_d;
  logic               restart_q, restart_d, dump_q, dump_d;
  logic               tvalid_q, tvalid_d, overrun_q, overrun_d;
  logic [OUT_W-1:0]   tdata_q, tdata_d, acc_flat;
  logic [15:0]        epoch_q, epoch_d;
  logic               clr, smp_en, is_last, hs, pend;

  assign clr     = i_stop | ((state_q == ST_IDLE) & i_start);
  assign smp_en  = s_axis_tvalid & (state_q == ST_INTEG) & ~i_stop;
  assign is_last = (cnt_q == last_idx_q);
  assign hs      = tvalid_q & m_axis_tready;
  // A result still travelling through the term/accumulator stages.
  assign pend    = term_vld_q | dump_q;

  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
    gnss_corr_tap_acc #(
      .SAMPLE_W (SAMPLE_W),
      .ACC_W    (ACC_W)
    ) u_tap (
      .clk     (axis_aclk),
      .rst     (axis_aresetn),
      .clr     (clr),
      .smp_en  (smp_en),
      .acc_en  (term_vld_q),
      .restart (restart_q),
      .code    (i_code[gi]),
      .smp_re  (s_axis_tdata[SAMPLE_W-1:0]),
      .smp_im  (s_axis_tdata[2*SAMPLE_W-1:SAMPLE_W]),
      .acc_re  (acc_flat[2*ACC_W*gi +: ACC_W]),
      .acc_im  (acc_flat[2*ACC_W*gi+ACC_W +: ACC_W])
    );
  end

  // Control pipeline that follows the sample through term and accumulator.
  always_comb begin
    term_vld_d  = smp_en;
    term_last_d = smp_en & is_last;
    restart_d   = term_vld_q ? term_last_q : restart_q;
    dump_d      = term_vld_q & term_last_q;
    if (clr) begin
      term_vld_d  = 1'b0;
      term_last_d = 1'b0;
      restart_d   = 1'b0;
      dump_d      = 1'b0;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    skip_d     = skip_q;
    last_idx_d = last_idx_q;
    cont_d     = cont_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    overrun_d  = overrun_q;
    epoch_d    = epoch_q;
    case (state_q)
      ST_IDLE: begin
        if (i_start && !i_stop) begin
          cnt_d      = '0;
          skip_d     = i_cfg_skip;
          last_idx_d = (i_cfg_len == '0) ? '0 : i_cfg_len - ONE;
          cont_d     = i_cfg_continuous;
          overrun_d  = 1'b0;
          epoch_d    = '0;
          state_d    = (i_cfg_skip != '0) ? ST_SKIP : ST_INTEG;
        end
      end
      ST_SKIP: begin
        if (s_axis_tvalid) begin
          if (cnt_q == skip_q - ONE) begin
            cnt_d   = '0;
            state_d = ST_INTEG;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      ST_INTEG: begin
        if (s_axis_tvalid) begin
          if (is_last) begin
            cnt_d = '0;
            if (!cont_q) state_d = ST_DRAIN;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        end
      end
      ST_DRAIN: begin
        // Leave only once the dumped result has reached the output and gone.
        if (hs && !pend) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (i_stop) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end

    if (hs) tvalid_d = 1'b0;

    if (dump_q && !i_stop) begin
      epoch_d = epoch_q + 16'd1;
      if (tvalid_q && !m_axis_tready) begin
        overrun_d = 1'b1;
      end else begin
        tdata_d  = acc_flat;
        tvalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
    if (axis_aresetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      skip_q      <= '0;
      last_idx_q  <= '0;
      cont_q      <= 1'b0;
      term_vld_q  <= 1'b0;
      term_last_q <= 1'b0;
      restart_q   <= 1'b0;
      dump_q      <= 1'b0;
      tvalid_q    <= 1'b0;
      tdata_q     <= '0;
      overrun_q   <= 1'b0;
      epoch_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      skip_q      <= skip_d;
      last_idx_q  <= last_idx_d;
      cont_q      <= cont_d;
      term_vld_q  <= term_vld_d;
      term_last_q <= term_last_d;
      restart_q   <= restart_d;
      dump_q      <= dump_d;
      tvalid_q    <= tvalid_d;
      tdata_q     <= tdata_d;
      overrun_q   <= overrun_d;
      epoch_q     <= epoch_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign o_busy        = (state_q != ST_IDLE);
  assign o_overrun     = overrun_q;
  assign o_epoch_count = epoch_q;

endmodule

// File: tb/tb_gnss_corr_bank.sv
// Randomised and directed bench for gnss_corr_bank with a scoreboard.
module tb_gnss_corr_bank;

  localparam int NT    = 6;
  localparam int SW    = 8;
  localparam int AW    = 10;
  localparam int LW    = 32;
  localparam int OUT_W = 2 * AW * NT;
  localparam int AMAX  = (1 << (AW - 1)) - 1;
  localparam int AMIN  = -(1 << (AW - 1));

  logic               clk = 1'b0;
  logic               rst;
  logic               i_start, i_stop, i_cfg_continuous;
  logic [LW-1:0]      i_cfg_len, i_cfg_skip;
  logic [2*SW-1:0]    s_axis_tdata;
  logic               s_axis_tvalid;
  logic [NT-1:0]      i_code;
  logic [OUT_W-1:0]   m_axis_tdata;
  logic               m_axis_tvalid, m_axis_tready;
  logic               o_busy, o_overrun;
  logic [15:0]        o_epoch_count;

  gnss_corr_bank #(.NUM_TAPS(NT), .SAMPLE_W(SW), .ACC_W(AW), .LEN_W(LW)) dut (
    .axis_aclk        (clk),
    .axis_aresetn     (rst),
    .i_start          (i_start),
    .i_stop           (i_stop),
    .i_cfg_len        (i_cfg_len),
    .i_cfg_skip       (i_cfg_skip),
    .i_cfg_continuous (i_cfg_continuous),
    .s_axis_tdata     (s_axis_tdata),
    .s_axis_tvalid    (s_axis_tvalid),
    .i_code           (i_code),
    .m_axis_tdata     (m_axis_tdata),
    .m_axis_tvalid    (m_axis_tvalid),
    .m_axis_tready    (m_axis_tready),
    .o_busy           (o_busy),
    .o_overrun        (o_overrun),
    .o_epoch_count    (o_epoch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [OUT_W-1:0] data;
    int               epoch;
  } exp_t;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   sb_en, model_on, auto_rdy;
  int   hold;

  // Reference model state: what an ideal correlator would have summed.
  int m_phase;  // 0 skipping, 1 integrating, 2 finished
  int m_skip_left, m_cnt, m_len, m_epoch;
  bit m_cont;
  int m_re[NT];
  int m_im[NT];

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int clamp(input int v);
    if (v > AMAX) return AMAX;
    if (v < AMIN) return AMIN;
    return v;
  endfunction

  function automatic int out_re(input int k);
    logic signed [AW-1:0] v;
    v = m_axis_tdata[2*AW*k +: AW];
    return v;
  endfunction

  function automatic int out_im(input int k);
    logic signed [AW-1:0] v;
    v = m_axis_tdata[2*AW*k+AW +: AW];
    return v;
  endfunction

  task automatic model_start(input int len, input int skip, input bit cont);
    m_len       = (len == 0) ? 1 : len;
    m_skip_left = skip;
    m_phase     = (skip != 0) ? 0 : 1;
    m_cnt       = 0;
    m_epoch     = 0;
    m_cont      = cont;
    for (int k = 0; k < NT; k++) begin
      m_re[k] = 0;
      m_im[k] = 0;
    end
  endtask

  task automatic model_sample(input int re, input int im, input logic [NT-1:0] code);
    exp_t e;
    if (!model_on) return;
    if (m_phase == 0) begin
      m_skip_left--;
      if (m_skip_left == 0) m_phase = 1;
    end else if (m_phase == 1) begin
      for (int k = 0; k < NT; k++) begin
        m_re[k] = clamp(m_re[k] + (code[k] ? re : -re));
        m_im[k] = clamp(m_im[k] + (code[k] ? im : -im));
      end
      m_cnt++;
      if (m_cnt == m_len) begin
        m_epoch++;
        e.data = '0;
        for (int k = 0; k < NT; k++) begin
          e.data[2*AW*k +: AW]    = AW'(m_re[k]);
          e.data[2*AW*k+AW +: AW] = AW'(m_im[k]);
          m_re[k] = 0;
          m_im[k] = 0;
        end
        e.epoch = m_epoch;
        sb_q.push_back(e);
        m_cnt = 0;
        if (!m_cont) m_phase = 2;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (m_axis_tvalid) hold++;
    else hold = 0;
    // Random back-pressure, but never long enough to provoke an overrun.
    if (auto_rdy) m_axis_tready = (hold >= 2) ? 1'b1 : 1'($urandom_range(0, 1));
  endtask

  task automatic drive(input int re, input int im, input logic [NT-1:0] code);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = {SW'(im), SW'(re)};
    i_code        = code;
    model_sample(re, im, code);
    step();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic start_run(input int len, input int skip, input bit cont);
    i_cfg_len        = LW'(len);
    i_cfg_skip       = LW'(skip);
    i_cfg_continuous = cont;
    i_start          = 1'b1;
    if (model_on) model_start(len, skip, cont);
    step();
    i_start          = 1'b0;
    // Config changes during a run must not matter.
    i_cfg_len        = LW'($urandom_range(1, 50));
    i_cfg_skip       = LW'($urandom_range(0, 50));
    i_cfg_continuous = 1'($urandom_range(0, 1));
    chk("busy_after_start", o_busy, 1);
  endtask

  task automatic stop_run();
    i_stop = 1'b1;
    m_phase = 2;
    step();
    i_stop = 1'b0;
    chk("busy_after_stop", o_busy, 0);
  endtask

  task automatic wait_valid(input int max);
    for (int n = 0; n < max && !m_axis_tvalid; n++) step();
    chk("wait_tvalid", m_axis_tvalid, 1);
  endtask

  // Monitor: every accepted beat is checked against the oldest prediction.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && sb_en && m_axis_tvalid && m_axis_tready) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected: got beat %h expected none", m_axis_tdata);
        end else begin
          e = sb_q.pop_front();
          total++;
          if (m_axis_tdata !== e.data) begin
            bad++;
            $display("FAIL sb_data: got %h expected %h", m_axis_tdata, e.data);
          end else begin
            $display("beat epoch=%0d data=%h", e.epoch, e.data);
          end
          chk("sb_epoch_count", o_epoch_count, e.epoch);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    i_start = 0; i_stop = 0; i_cfg_len = '0; i_cfg_skip = '0; i_cfg_continuous = 0;
    s_axis_tdata = '0; s_axis_tvalid = 0; i_code = '0; m_axis_tready = 0;
    sb_en = 0; model_on = 0; auto_rdy = 0; hold = 0; m_phase = 2;
    fork
      monitor();
    join_none
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_epoch", o_epoch_count, 0);
    chk("rst_tdata_zero", (m_axis_tdata == '0), 1);
    rst = 1'b0;
    step();
    sb_en = 1; model_on = 1;

    // Single epoch, skip 2, len 4, constant I=3 Q=-2, all chips +1.
    start_run(4, 2, 0);
    for (int i = 0; i < 6; i++) drive(3, -2, '1);
    chk("lat_plus1", m_axis_tvalid, 0);
    step();
    chk("lat_plus2", m_axis_tvalid, 0);
    step();
    chk("lat_plus3", m_axis_tvalid, 1);
    for (int k = 0; k < NT; k++) begin
      chk("single_re", out_re(k), 12);
      chk("single_im", out_im(k), -8);
    end
    m_axis_tready = 1;
    step();
    chk("single_tvalid_clear", m_axis_tvalid, 0);
    chk("single_idle", o_busy, 0);

    // Continuous len 3, I=1 every cycle, always ready.
    start_run(3, 0, 1);
    for (int i = 0; i < 9; i++) drive(1, 0, NT'($urandom));
    idle(5);
    chk("cont_epochs", o_epoch_count, 3);
    stop_run();

    // Negating the most negative sample.
    start_run(2, 0, 0);
    for (int i = 0; i < 2; i++) drive(-128, $urandom_range(0, 255) - 128, {NT'($urandom) & ~NT'(3)} | NT'(1));
    wait_valid(10);
    chk("neg_tap0_re", out_re(0), -256);
    chk("neg_tap1_re", out_re(1), 256);
    idle(3);

    // Saturation in both directions.
    start_run(10, 0, 0);
    for (int i = 0; i < 10; i++) drive(127, -128, '1);
    wait_valid(10);
    chk("sat_re_max", out_re(0), AMAX);
    chk("sat_im_min", out_im(0), AMIN);
    idle(3);

    // Randomised runs with random gaps and back-pressure.
    auto_rdy = 1;
    for (int r = 0; r < 6; r++) begin
      start_run($urandom_range(3, 6), $urandom_range(0, 3), (r % 3) != 0);
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 9) < 7) drive($urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128, NT'($urandom));
        else idle(1);
      end
      idle(6);
      stop_run();
      for (int n = 0; n < 60 && sb_q.size() != 0; n++) step();
      chk("sb_drained", sb_q.size(), 0);
    end

    // Overrun: three epochs with no acceptance.
    auto_rdy = 0; m_axis_tready = 0; sb_en = 0; model_on = 0;
    idle(2);
    start_run(2, 0, 1);
    drive(5, 0, '1); drive(5, 0, '1);
    drive(7, 0, '1); drive(7, 0, '1);
    drive(9, 0, '1); drive(9, 0, '1);
    idle(4);
    chk("ovr_tvalid", m_axis_tvalid, 1);
    chk("ovr_held_re", out_re(0), 10);
    chk("ovr_flag", o_overrun, 1);
    chk("ovr_epochs", o_epoch_count, 3);
    m_axis_tready = 1;
    step();
    m_axis_tready = 0;
    chk("ovr_drained", m_axis_tvalid, 0);
    stop_run();

    // Stop (with simultaneous start) mid-epoch while a result is pending.
    start_run(3, 0, 1);
    chk("start_clears_ovr", o_overrun, 0);
    drive(2, 0, '1); drive(2, 0, '1); drive(2, 0, '1);
    drive(1, 0, '1); drive(1, 0, '1);
    i_stop = 1; i_start = 1;
    step();
    i_stop = 0; i_start = 0;
    chk("stop_idle", o_busy, 0);
    chk("stop_keeps_tvalid", m_axis_tvalid, 1);
    chk("stop_keeps_data", out_re(0), 6);
    step();
    chk("stop_beats_start", o_busy, 0);
    m_axis_tready = 1;
    step();
    m_axis_tready = 0;
    chk("stop_pending_taken", m_axis_tvalid, 0);
    start_run(0, 0, 0);
    drive(3, 0, '1);
    wait_valid(10);
    chk("len0_fresh_re", out_re(0), 3);
    chk("len0_epoch", o_epoch_count, 1);
    m_axis_tready = 1;
    step();
    m_axis_tready = 0;
    idle(2);

    // Asynchronous reset mid-INTEG with a pending result.
    start_run(3, 0, 1);
    drive(4, 1, '1); drive(4, 1, '1); drive(4, 1, '1); drive(4, 1, '1);
    idle(2);
    chk("pre_rst_tvalid", m_axis_tvalid, 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_tvalid", m_axis_tvalid, 0);
    chk("arst_busy", o_busy, 0);
    chk("arst_overrun", o_overrun, 0);
    chk("arst_epoch", o_epoch_count, 0);
    chk("arst_tdata_zero", (m_axis_tdata == '0), 1);
    @(posedge clk);
    #1;
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
